// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits needed to show the largest bin_w-bit unsigned value.
    function automatic int max_digits(input int bin_w);
        longint unsigned v;
        int              d;
        v = (bin_w >= 64) ? '1 : ((64'd1 << bin_w) - 64'd1);
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                d++;
                v = v / 64'd10;
            end
        end
        if (d == 0) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_convert_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with start/done handshake, registered result and overflow flag.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [BIN_W-1:0]                bin,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
    output logic                            overflow
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
        $error("bcd_convert_seq: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bcd_convert_seq: DIGITS=%0d outside 1..10", DIGITS);
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [BIN_W-1:0]   r_shreg;
    logic [SCR_W-1:0]   r_scratch;
    logic [SCR_W-1:0]   w_adj;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_count;
    logic [SCR_W-1:0]   r_bcd;
    logic               r_overflow;
    logic               r_done;
    logic               w_load;
    logic               w_shift;
    logic               w_finish;
    logic               w_busy;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (r_count == '0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_state == IDLE) && start;
        w_shift  = (r_state == SHIFT);
        w_finish = (r_state == DONE);
        w_busy   = (r_state != IDLE);
    end

    // Digits are adjusted before every shift; the bit leaving the top digit marks overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_scratch  <= '0;
            r_ovf      <= 1'b0;
            r_count    <= '0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_shreg   <= bin;
                r_scratch <= '0;
                r_ovf     <= 1'b0;
                r_count   <= CNT_W'(BIN_W - 1);
            end else if (w_shift) begin
                r_scratch <= {w_adj[SCR_W-2:0], r_shreg[BIN_W-1]};
                r_shreg   <= {r_shreg[BIN_W-2:0], 1'b0};
                r_ovf     <= r_ovf | w_adj[SCR_W-1];
                if (r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end
            end
            if (w_finish) begin
                r_bcd      <= r_scratch;
                r_overflow <= r_ovf;
            end
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: three parameterisations, scoreboard queues, table + corner sequences.
module tb_bcd_convert_seq;

    typedef struct packed {
        logic [39:0] bcd;
        logic        ovf;
        logic        chk_bcd;
    } exp_t;

    typedef struct packed {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    logic        start0, busy0, done0, ovf0;
    logic [15:0] bin0;
    logic [19:0] bcd0;
    logic        start1, busy1, done1, ovf1;
    logic [7:0]  bin1;
    logic [11:0] bcd1;
    logic        start2, busy2, done2, ovf2;
    logic [15:0] bin2;
    logic [15:0] bcd2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_convert_seq dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0)
    );
    bcd_convert_seq #(.BIN_W(8), .DIGITS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
    );
    bcd_convert_seq #(.BIN_W(16), .DIGITS(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    // Reference by repeated division, independent of the shift-and-add method.
    function automatic logic [40:0] model(input logic [31:0] v, input int digits);
        logic [40:0] r;
        logic [31:0] x;
        r = '0;
        x = v;
        for (int i = 0; i < 10; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'(x % 32'd10);
                x = x / 32'd10;
            end
        end
        r[40] = (x != 32'd0);
        return r;
    endfunction

    task automatic check_res(input string nm, input exp_t e, input logic [39:0] got_bcd, input logic got_ovf);
        chk({nm, "_ovf"}, 64'(got_ovf), 64'(e.ovf));
        if (e.chk_bcd) chk({nm, "_bcd"}, 64'(got_bcd), 64'(e.bcd));
        $display("done %s bcd=%h ovf=%0b", nm, got_bcd, got_ovf);
    endtask

    always @(negedge clk) begin
        if (rst_n && done0) begin
            if (q0.size() == 0) chk("dut0_unexpected_done", 64'(1), 64'(0));
            else begin e0 = q0.pop_front(); check_res("dut0", e0, {20'b0, bcd0}, ovf0); end
        end
        if (rst_n && done1) begin
            if (q1.size() == 0) chk("dut1_unexpected_done", 64'(1), 64'(0));
            else begin e1 = q1.pop_front(); check_res("dut1", e1, {28'b0, bcd1}, ovf1); end
        end
        if (rst_n && done2) begin
            if (q2.size() == 0) chk("dut2_unexpected_done", 64'(1), 64'(0));
            else begin e2 = q2.pop_front(); check_res("dut2", e2, {24'b0, bcd2}, ovf2); end
        end
    end

    task automatic wait_done(input int which, output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && done0) || (which == 1 && done1) || (which == 2 && done2)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic conv(input int which, input logic [15:0] v, input logic [39:0] eb,
                        input logic eo, input int exp_lat);
        exp_t e;
        int   lat;
        e.bcd = eb;
        e.ovf = eo;
        e.chk_bcd = !eo;
        @(negedge clk);
        case (which)
            0:       begin bin0 = v;      start0 = 1'b1; q0.push_back(e); end
            1:       begin bin1 = v[7:0]; start1 = 1'b1; q1.push_back(e); end
            default: begin bin2 = v;      start2 = 1'b1; q2.push_back(e); end
        endcase
        @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        wait_done(which, lat);
        chk($sformatf("dut%0d_latency_bin%0d", which, v), 64'(lat), 64'(exp_lat));
        if (which == 0) chk("dut0_busy_at_done", 64'(busy0), 64'(0));
    endtask

    vec_t        tbl[6];
    logic [40:0] m;
    logic [15:0] rv;
    int          lat, d1, d2, d3;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{bin: 16'd65535, bcd: 20'h65535, ovf: 1'b0};
        tbl[1] = '{bin: 16'd0,     bcd: 20'h00000, ovf: 1'b0};
        tbl[2] = '{bin: 16'd10000, bcd: 20'h10000, ovf: 1'b0};
        tbl[3] = '{bin: 16'd12345, bcd: 20'h12345, ovf: 1'b0};
        tbl[4] = '{bin: 16'd9,     bcd: 20'h00009, ovf: 1'b0};
        tbl[5] = '{bin: 16'd4096,  bcd: 20'h04096, ovf: 1'b0};

        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bin0 = '0; bin1 = '0; bin2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bcd0", 64'(bcd0), 64'(0));
        chk("reset_ovf0", 64'(ovf0), 64'(0));
        chk("reset_busy0", 64'(busy0), 64'(0));
        chk("reset_done0", 64'(done0), 64'(0));
        chk("reset_bcd1", 64'(bcd1), 64'(0));
        chk("reset_busy2", 64'(busy2), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        conv(1, 16'd255, 40'h255, 1'b0, 9);
        conv(2, 16'd9999, 40'h9999, 1'b0, 17);
        conv(2, 16'd10000, 40'h0, 1'b1, 17);

        for (int i = 0; i < 6; i++) conv(0, tbl[i].bin, {20'b0, tbl[i].bcd}, tbl[i].ovf, 17);
        for (int i = 0; i < 5; i++) begin
            rv = 16'($urandom_range(0, 65535));
            m = model({16'b0, rv}, 5);
            conv(0, rv, m[39:0], m[40], 17);
            rv = 16'($urandom_range(0, 65535));
            m = model({16'b0, rv}, 4);
            conv(2, rv, m[39:0], m[40], 17);
        end

        // Start held high: back-to-back conversions of 1, 2, 3.
        @(negedge clk);
        start0 = 1'b1;
        bin0 = 16'd1;
        q0.push_back('{bcd: 40'h1, ovf: 1'b0, chk_bcd: 1'b1});
        q0.push_back('{bcd: 40'h2, ovf: 1'b0, chk_bcd: 1'b1});
        q0.push_back('{bcd: 40'h3, ovf: 1'b0, chk_bcd: 1'b1});
        @(posedge clk);
        #1 bin0 = 16'd2;
        wait_done(0, lat);
        d1 = cyc;
        chk("b2b_first_latency", 64'(lat), 64'(17));
        @(posedge clk);
        #1 bin0 = 16'd3;
        wait_done(0, lat);
        d2 = cyc;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_done(0, lat);
        d3 = cyc;
        chk("b2b_spacing_1_2", 64'(d2 - d1), 64'(18));
        chk("b2b_spacing_2_3", 64'(d3 - d2), 64'(18));

        // A start pulse during SHIFT is ignored.
        @(negedge clk);
        bin0 = 16'd777;
        start0 = 1'b1;
        q0.push_back('{bcd: 40'h777, ovf: 1'b0, chk_bcd: 1'b1});
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midshift_busy", 64'(busy0), 64'(1));
        chk("midshift_bcd_holds", 64'(bcd0), 64'(20'h3));
        start0 = 1'b1;
        bin0 = 16'd999;
        @(posedge clk);
        #1 start0 = 1'b0;
        bin0 = 16'd0;
        wait_done(0, lat);
        chk("midshift_latency", 64'(lat), 64'(12));
        repeat (25) @(posedge clk);
        #1 chk("midshift_q0_drained", 64'(q0.size()), 64'(0));

        // Reset at cycle 5 of a conversion of 12345: no done, outputs clear at once.
        @(negedge clk);
        bin0 = 16'd12345;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_bcd0", 64'(bcd0), 64'(0));
        chk("abort_ovf0", 64'(ovf0), 64'(0));
        chk("abort_busy0", 64'(busy0), 64'(0));
        chk("abort_done0", 64'(done0), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        conv(0, 16'd42, 40'h00042, 1'b0, 17);

        repeat (3) @(posedge clk);
        #1;
        chk("final_q0_empty", 64'(q0.size()), 64'(0));
        chk("final_q1_empty", 64'(q1.size()), 64'(0));
        chk("final_q2_empty", 64'(q2.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
